io_input_controller: RTL and testbench
======================================

# io_input_controller

Synchronous input stage for the ZAFx32 core. It debounces the board push-button and synchronizes the board switches. On an IN instruction it stalls the core until the user presses the button. It then drives the latched switch value onto the CPU `dataIn` bus with a one-cycle `enter` pulse, so the core writes it to the register file and advances the PC.

## Interface

Parameters:
- `SW_WIDTH`, default 16: number of board switches; range 1–32.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles needed to accept a button level change; must be ≥ 1.

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `switches`  in  SW_WIDTH  raw asynchronous switch levels.
- `button`  in  1  raw asynchronous push-button, active-high.
- `in_req`  in  1  level signal from the control unit; high while the decoded instruction is IN.
- `dataIn`  out  32  extended switch value; goes to the CPU `dataIn` input.
- `enter`  out  1  one-cycle pulse; goes to the CPU `enter` input.
- `stall`  out  1  freezes the core while high (PC hold, regwrite and memwrite gated).

## Operation

- **Synchronizers:** two-flop synchronizer on `button` and a two-flop synchronizer on every `switches` bit.
- **Debounce counter:**
  - Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
  - The counter increments while synchronized button ≠ `btn_stable`, and clears to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES − 1 and the values still differ, `btn_stable` toggles on the next edge and the counter clears.
- **Press event:** `btn_stable` = 1 and its one-cycle-delayed copy = 0. A held button produces exactly one event.
- **FSM states:** IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE. Transitions:
  - IDLE: `in_req` = 1 → WAIT_PRESS.
  - WAIT_PRESS:
    - press event → CAPTURE; the synchronized switches are latched into `dataIn` on the same edge.
    - `in_req` = 0 → IDLE, with no capture.
  - CAPTURE: always → WAIT_RELEASE after one cycle.
  - WAIT_RELEASE: `btn_stable` = 0 → IDLE.
- **Combinational outputs:**
  - `stall` = `in_req` AND state ≠ CAPTURE. The stall covers the first cycle `in_req` appears and any `in_req` raised in WAIT_RELEASE.
  - `enter` = (state == CAPTURE).
- **Data retention:** `dataIn` holds the last captured value until the next capture.
- **Extension:** the switch MSB maps to the `dataIn` MSB side. Upper bits are filled per the Configuration section.
- **Back-to-back IN instructions:** the second IN stays stalled through WAIT_RELEASE and IDLE. It captures only after the button has been released and pressed again.

## Timing

- **Reset values:**
  - state = IDLE; `dataIn` = 32'h0; `enter` = 0.
  - `btn_stable` = 0, delayed copy = 0, debounce counter = 0, synchronizer flops = 0.
  - `stall` = `in_req` during and after reset.
- **Press latency:** a clean raw rising edge of `button` sampled at edge N gives:
  - synchronized button = 1 after edge N+1;
  - `btn_stable` = 1 after edge N+1+DEBOUNCE_CYCLES;
  - `enter` = 1 and new `dataIn` valid in the cycle after edge N+2+DEBOUNCE_CYCLES.
- **Capture cycle:**
  - `stall` = 0 in the same cycle as `enter`, so the core commits in that cycle.
  - `enter` is high for exactly one cycle per press.
- **Glitch rejection:** any button glitch shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- **Reset mid-operation:**
  - Any state returns to IDLE and no `enter` is issued.
  - A button held through reset is re-debounced from `btn_stable` = 0 and produces one press event.
- **Simultaneous events:** if a press event occurs in the same cycle `in_req` falls in WAIT_PRESS, `in_req` = 0 wins. The state goes to IDLE and there is no capture.
- **Switches:** sampled only on the capture edge; changes at any other time have no effect.

## Configuration

- Macro: `IO_INPUT_SIGN_EXTEND_EN`.
- Defined: `dataIn` = switches sign-extended to 32 bits, replicating `switches[MSB]`.
- Undefined (default): `dataIn` = switches zero-extended to 32 bits.
- Debounce, FSM and timing are identical in both builds.

## Test plan

- **Reset:** assert `reset` 3 cycles with `in_req` = 0, `button` = 1, then release. Required: `dataIn` = 0, `enter` = 0, `stall` = 0 throughout.
- **Clean press** (DEBOUNCE_CYCLES = 4, SW_WIDTH = 16, switches = 16'h00A5, `in_req` = 1 from cycle 0, `button` rises at edge 10):
  - `stall` = 1 for cycles 0–16;
  - `enter` = 1 only in cycle 17 with `dataIn` = 32'h000000A5 and `stall` = 0.
- **Bounce:** `button` toggles every 2 cycles for 12 cycles, then stays at 1. Required: exactly one `enter` pulse, 7 cycles after the final rising edge.
- **Held button across two INs:** button stays held after a capture and a second `in_req` arrives. Required: `stall` stays 1 and there is no `enter` until release plus a new press.
- **Sign extension:** switches = 16'h8001. Required: `dataIn` = 32'hFFFF8001 with `IO_INPUT_SIGN_EXTEND_EN` defined; 32'h00008001 without it.
- **Reset in WAIT_PRESS:** pulse `reset` with the debounce counter at 2. Required: no `enter`; `stall` follows `in_req`; a subsequent full press captures normally.

Source files
------------

// File: rtl/io_input_controller.sv
// Input stage for the ZAFx32 core: button debounce, switch sync and IN-instruction handshake.
// Build option: define IO_INPUT_SIGN_EXTEND_EN to sign-extend switches onto dataIn (default zero-extend).
module io_input_controller #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                button,
  input  logic                in_req,
  output logic [31:0]         dataIn,
  output logic                enter,
  output logic                stall
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // state        | meaning
  // IDLE         | no IN pending
  // WAIT_PRESS   | IN pending, core stalled until a press event
  // CAPTURE      | switches latched, enter pulse, core commits
  // WAIT_RELEASE | waiting for the debounced button to drop
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE} state_e;

  state_e              state_q, state_d;
  logic                btn_meta_q, btn_sync_q;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stable_q, stable_d;
  logic                stable_dly_q;
  logic [31:0]         data_q, data_d;
  logic [31:0]         sw_ext;
  logic                fill;
  logic                press;
  logic                capture;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      data_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      btn_meta_q   <= button;
      btn_sync_q   <= btn_meta_q;
      sw_meta_q    <= switches;
      sw_sync_q    <= sw_meta_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      data_q       <= data_d;
    end
  end

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (btn_sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = ~stable_q;
      else                   cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  assign press = stable_q & ~stable_dly_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE:         if (in_req) state_d = WAIT_PRESS;
      WAIT_PRESS: begin
        if (!in_req) begin
          state_d = IDLE;
        end else if (press) begin
          state_d = CAPTURE;
          capture = 1'b1;
        end
      end
      CAPTURE:      state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!stable_q) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef IO_INPUT_SIGN_EXTEND_EN
    fill = sw_sync_q[SW_WIDTH-1];
`else
    fill = 1'b0;
`endif
    sw_ext                 = {32{fill}};
    sw_ext[SW_WIDTH-1:0]   = sw_sync_q;
    data_d                 = capture ? sw_ext : data_q;
  end

  always_comb begin
    enter  = (state_q == CAPTURE);
    stall  = in_req & (state_q != CAPTURE);
    dataIn = data_q;
  end

endmodule

// File: tb/tb_io_input_controller.sv
// Scoreboard bench for io_input_controller: behavioural model predicts captures, monitor checks them.
module tb_io_input_controller;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switches;
  logic        button;
  logic        in_req;
  logic [31:0] dataIn;
  logic        enter;
  logic        stall;

  io_input_controller #(.SW_WIDTH(16), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .switches(switches), .button(button),
    .in_req(in_req), .dataIn(dataIn), .enter(enter), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          edge_no;
    logic [31:0] data;
  } cap_t;

  cap_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ecount   = -1;
  bit mon_en   = 0;
  int n_enter  = 0;
  int last_enter_edge = -1;
  logic [31:0] last_data = 32'h0;

  // Reference model state: delay lines for the synchronizers, accepted level,
  // length of the current disagreement run, and the IN handshake phase flags.
  logic        m_b1, m_b2, m_acc, m_prev;
  logic [15:0] m_sw1, m_sw2;
  int          m_run;
  bit          m_waiting, m_enter, m_release;
  logic [31:0] m_data;

  function automatic logic [31:0] ext(input logic [15:0] s);
`ifdef IO_INPUT_SIGN_EXTEND_EN
    return {{16{s[15]}}, s};
`else
    return {16'h0000, s};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
    else
      n_pass++;
  endtask

  always @(posedge clock) begin
    bit press, new_enter;
    ecount++;
    mon_en = 1;
    if (reset) begin
      {m_b1, m_b2, m_acc, m_prev} = '0;
      m_sw1 = '0; m_sw2 = '0; m_run = 0;
      m_waiting = 0; m_enter = 0; m_release = 0;
      m_data = 32'h0;
    end else begin
      press     = m_acc && !m_prev;
      new_enter = 0;
      if (m_enter) begin
        m_release = 1;
      end else if (m_release) begin
        if (!m_acc) m_release = 0;
      end else if (m_waiting) begin
        if (!in_req) begin
          m_waiting = 0;
        end else if (press) begin
          m_waiting = 0;
          new_enter = 1;
          m_data    = ext(m_sw2);
          sb_q.push_back('{edge_no: ecount, data: m_data});
        end
      end else if (in_req) begin
        m_waiting = 1;
      end
      m_enter = new_enter;
      m_prev  = m_acc;
      if (m_b2 != m_acc) begin
        m_run++;
        if (m_run == D) begin
          m_acc = !m_acc;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_b2 = m_b1; m_b1 = button;
      m_sw2 = m_sw1; m_sw1 = switches;
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("stall", stall, in_req && !m_enter);
      chk("enter", enter, m_enter);
      chk("dataIn", dataIn, m_data);
      if (enter) begin
        n_enter++;
        last_enter_edge = ecount;
        last_data       = dataIn;
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          cap_t e;
          e = sb_q.pop_front();
          chk("capture_edge", ecount, e.edge_no);
          chk("capture_data", dataIn, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    int nb, e0;
    reset = 1; in_req = 0; button = 1; switches = 16'h0;
    tick(3);
    reset = 0; button = 0;
    tick(10);

    // clean press
    switches = 16'h00A5; in_req = 1;
    tick(5);
    button = 1; nb = ecount + 1; e0 = n_enter;
    tick(D + 4);
    chk("clean_count", n_enter - e0, 1);
    chk("clean_latency", last_enter_edge - nb, D + 2);
    chk("clean_data", last_data, 32'h0000_00A5);
    in_req = 0;
    tick(1);
    button = 0;
    tick(D + 4);

    // bounce then held button across a second IN
    in_req = 1; switches = 16'h1234; e0 = n_enter;
    for (int i = 0; i < 6; i++) begin
      button = (i % 2 == 0);
      tick(2);
    end
    button = 1; nb = ecount + 1;
    tick(D + 6);
    chk("bounce_count", n_enter - e0, 1);
    chk("bounce_latency", last_enter_edge - nb, D + 2);
    tick(20);
    chk("held_no_enter", n_enter - e0, 1);
    button = 0;
    tick(D + 3);
    button = 1;
    tick(D + 5);
    chk("held_repress", n_enter - e0, 2);
    in_req = 0; button = 0;
    tick(D + 4);

    // extension of a negative switch value
    switches = 16'h8001; in_req = 1; button = 1;
    tick(D + 5);
`ifdef IO_INPUT_SIGN_EXTEND_EN
    chk("extend", last_data, 32'hFFFF_8001);
`else
    chk("extend", last_data, 32'h0000_8001);
`endif
    in_req = 0; button = 0;
    tick(D + 4);

    // reset while waiting for a press
    in_req = 1;
    tick(2);
    button = 1;
    tick(4);
    reset = 1; button = 0; e0 = n_enter;
    tick(1);
    reset = 0;
    tick(D + 4);
    chk("rst_no_enter", n_enter - e0, 0);
    button = 1;
    tick(D + 5);
    chk("rst_then_press", n_enter - e0, 1);
    in_req = 0; button = 0;
    tick(D + 4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 39) == 0);
      in_req   = ($urandom_range(0, 9) < 7);
      button   = 1'($urandom_range(0, 1));
      switches = 16'($urandom);
      tick($urandom_range(1, 8));
    end
    reset = 0; in_req = 0; button = 0;
    tick(20);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
